// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte-stream input and instruction-memory write bus of the loader.
//
// Byte stream (valid/ready): the source drives byteIn and raises byteValid and
// keeps both stable until a transfer happens. A transfer takes place on a rising
// clk edge where byteValid=1 and byteReady=1. byteReady does not depend on
// byteValid.
//
// Memory write: memWrite is a one-cycle strobe. memAddress (byte address,
// word-aligned) and memData are valid while memWrite=1 and hold their values
// otherwise.
//
// Modports:
//   master -- stream source / memory sink (drives bytes, observes writes)
//   slave  -- the loader (consumes bytes, issues writes)
interface imem_loader_if;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memData;

  modport master (
    output byteIn, byteValid,
    input  byteReady, memWrite, memAddress, memData
  );

  modport slave (
    input  byteIn, byteValid,
    output byteReady, memWrite, memAddress, memData
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader -- loads a program into instruction memory from a byte stream,
// holding the CPU datapath in reset until the whole image has been written.
//
// Stream: 2-byte little-endian word count N, then 4*N little-endian words.
// N==0 or N>WORDS aborts the session into the error state.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   reset      asynchronous active-low reset
//   start      one-cycle request for a new session (honoured when idle/done/error)
//   bus        imem_loader_if.slave: byte stream in, memory write strobe out
//   cpuResetN  datapath released (1) only after a successful load
//   busy       session in progress
//   done       session completed (sticky until next honoured start)
//   error      session failed (sticky until next honoured start)
//   dbg_state  current FSM state encoding, for observation only
module imem_loader #(
  parameter int          WORDS = 64,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpuResetN,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR_LO  = 3'd1,
    S_HDR_HI  = 3'd2,
    S_COLLECT = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  localparam logic [31:0] WORDS_W = 32'(WORDS);

  state_t      state_q,    state_d;
  logic [15:0] n_q,        n_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q,     word_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;

  logic        ready;
  logic        accept;
  logic [15:0] n_full;
  logic [15:0] word_idx_inc;

  assign ready  = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) || (state_q == S_COLLECT);
  assign accept = ready && bus.byteValid;
  // Complete word count as it would be once the high header byte is taken.
  assign n_full       = {bus.byteIn, n_q[7:0]};
  assign word_idx_inc = word_idx_q + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      mem_addr_q <= BASE;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR_LO;
          n_d        = '0;
          word_idx_d = '0;
          byte_idx_d = '0;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          n_d[7:0] = bus.byteIn;
          state_d  = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          n_d = n_full;
          if ((n_full == 16'd0) || ({16'd0, n_full} > WORDS_W)) state_d = S_ERR;
          else                                                  state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          word_d[8*byte_idx_q +: 8] = bus.byteIn;
          byte_idx_d                = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Latch the write bus here so it holds after WRITE, when wordIdx moves on.
            state_d    = S_WRITE;
            mem_addr_d = BASE + {14'd0, word_idx_q, 2'b00};
            mem_data_d = {bus.byteIn, word_q[23:0]};
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_inc;
        byte_idx_d = '0;
        if (word_idx_inc == n_q) state_d = S_DONE;
        else                     state_d = S_COLLECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.byteReady  = ready;
  assign bus.memWrite   = (state_q == S_WRITE);
  assign bus.memAddress = mem_addr_q;
  assign bus.memData    = mem_data_q;

  assign busy      = ready || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign cpuResetN = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int          WORDS = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cpuResetN;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] dbg_state;

  imem_loader_if bus ();

  imem_loader #(.WORDS(WORDS), .BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpuResetN (cpuResetN),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  int          wr_seen = 0;
  int          exp_writes = 0;
  int          send_count = 0;
  bit          exp_err = 1'b0;
  logic [63:0] exp_q[$];
  logic [7:0]  stim_q[$];
  logic [63:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.memWrite === 1'b1) begin
      wr_seen++;
      check("ready_low_in_write", {63'd0, bus.byteReady}, 64'd0);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 bus.memAddress, bus.memData);
      end else begin
        mon_exp = exp_q.pop_front();
        checks--;
        check("write_addr_data", {bus.memAddress, bus.memData}, mon_exp);
      end
    end
  end

  // ---------------- reference model ----------------
  // Expected behaviour derived directly from the stream format.
  task automatic model_expect();
    int n;
    n = {stim_q[1], stim_q[0]};
    exp_err = (n == 0) || (n > WORDS);
    exp_writes = 0;
    send_count = 2;
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({BASE + 32'(4 * i),
                         stim_q[2 + 4*i + 3], stim_q[2 + 4*i + 2],
                         stim_q[2 + 4*i + 1], stim_q[2 + 4*i]});
      end
      exp_writes = n;
      send_count = 2 + 4 * n;
    end
  endtask

  task automatic build_stream(input int n);
    logic [15:0] nn;
    nn = 16'(n);
    stim_q.delete();
    stim_q.push_back(nn[7:0]);
    stim_q.push_back(nn[15:8]);
    if (n >= 1 && n <= WORDS)
      for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic load_req037();
    stim_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    exp_q.push_back({32'h0000_0000, 32'h0000_0513});
    exp_q.push_back({32'h0000_0004, 32'h0010_0593});
    exp_err    = 1'b0;
    exp_writes = 2;
    send_count = 10;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start",  {63'd0, busy},      64'd1);
    check("done_after_start",  {63'd0, done},      64'd0);
    check("error_after_start", {63'd0, error},     64'd0);
    check("cpurst_after_start",{63'd0, cpuResetN}, 64'd0);
  endtask

  // mode: 0 = valid held, 1 = valid toggles each cycle, 2 = random valid.
  task automatic send_bytes(input int count, input int mode, input int start_at);
    int idx = 0;
    int cyc = 0;
    bit ph  = 1'b0;
    bit v;
    bit acc;
    bit pulsed = 1'b0;
    while (idx < count) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
      ph = ~ph;
      bus.byteIn    = stim_q[idx];
      bus.byteValid = v;
      if (idx == start_at && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      acc = v && bus.byteReady;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
      if (cyc > count * 8 + 100) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: got %0d bytes accepted expected %0d", idx, count);
        break;
      end
    end
    bus.byteValid = 1'b0;
    start         = 1'b0;
  endtask

  task automatic finish_session();
    int k = 0;
    while (!(done || error) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) begin
      checks++;
      failures++;
      $display("FAIL end_timeout: got done=%b error=%b expected one set", done, error);
    end
    check("end_done",      {63'd0, done},          {63'd0, !exp_err});
    check("end_error",     {63'd0, error},         {63'd0, exp_err});
    check("end_cpuresetn", {63'd0, cpuResetN},     {63'd0, !exp_err});
    check("end_busy",      {63'd0, busy},          64'd0);
    check("end_ready",     {63'd0, bus.byteReady}, 64'd0);
    check("end_write_cnt", 64'(wr_seen),           64'(exp_writes));
    check("end_queue_left",64'(exp_q.size()),      64'd0);
    exp_q.delete();
  endtask

  task automatic run_session(input int mode, input int start_at);
    wr_seen = 0;
    do_start();
    send_bytes(send_count, mode, start_at);
    finish_session();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   {63'd0, bus.byteReady}, 64'd0);
    check({tag, "_memwrite"},{63'd0, bus.memWrite},  64'd0);
    check({tag, "_addr"},    {32'd0, bus.memAddress},{32'd0, BASE});
    check({tag, "_data"},    {32'd0, bus.memData},   64'd0);
    check({tag, "_cpurstn"}, {63'd0, cpuResetN},     64'd0);
    check({tag, "_busy"},    {63'd0, busy},          64'd0);
    check({tag, "_done"},    {63'd0, done},          64'd0);
    check({tag, "_error"},   {63'd0, error},         64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r;
    int n;
    reset         = 1'b0;
    start         = 1'b0;
    bus.byteIn    = 8'h00;
    bus.byteValid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // Reference program, valid held high.
    load_req037();
    run_session(0, -1);

    // Same program, valid toggling.
    load_req037();
    run_session(1, -1);

    // Zero-length header, then recovery with a valid stream.
    stim_q = '{8'h00, 8'h00};
    model_expect();
    run_session(0, -1);
    build_stream(1);
    model_expect();
    run_session(0, -1);

    // Oversized header.
    stim_q = '{8'h41, 8'h00};
    model_expect();
    run_session(0, -1);

    // Start pulses while collecting payload are ignored.
    load_req037();
    run_session(0, 4);

    // Reset in the middle of a session.
    build_stream(2);
    wr_seen = 0;
    do_start();
    send_bytes(4, 0, -1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midreset");
    check("midreset_writes", 64'(wr_seen), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    build_stream(1);
    model_expect();
    run_session(0, -1);

    // Largest allowed image.
    build_stream(WORDS);
    model_expect();
    run_session(2, -1);

    // Randomized sessions.
    for (int s = 0; s < 12; s++) begin
      r = $urandom_range(0, 9);
      n = (r == 0) ? 0 : (r == 1) ? $urandom_range(WORDS + 1, 1000) : $urandom_range(1, 6);
      build_stream(n);
      model_expect();
      run_session($urandom_range(0, 2), ($urandom_range(0, 1) == 1) ? $urandom_range(0, send_count - 1) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter WORDS, default 64, SHALL set the instruction-memory capacity in 32-bit words.
REQ-002 Parameter BASE, default 32'h00000000, SHALL set the byte address of word 0.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a new load session when high for one cycle.
REQ-006 byteIn  input  8  SHALL carry the stream byte.
REQ-007 byteValid  input  1  SHALL mark byteIn as valid.
REQ-008 byteReady  output  1  SHALL indicate the loader accepts a byte this cycle.
REQ-009 memWrite  output  1  SHALL be the instruction-memory write strobe.
REQ-010 memAddress  output  32  SHALL be the byte address for the write, word-aligned.
REQ-011 memData  output  32  SHALL be the instruction word to write.
REQ-012 cpuResetN  output  1  SHALL hold the datapath in reset while low.
REQ-013 busy, done, error  output  1 each  SHALL report session active, session completed and session failed.

Function
REQ-014 The FSM SHALL have the states IDLE, HDR_LO, HDR_HI, COLLECT, WRITE, DONE and ERR.
REQ-015 A byte SHALL transfer only on a rising edge with byteValid=1 and byteReady=1.
REQ-016 byteReady SHALL be 1 only in HDR_LO, HDR_HI and COLLECT.
REQ-017 Stream format: a 2-byte little-endian word count N (low byte first), then 4N instruction bytes.
REQ-018 start SHALL be honoured in IDLE, DONE and ERR: the FSM goes to HDR_LO, and done, error and the counters clear next cycle.
REQ-019 start SHALL be ignored in HDR_LO, HDR_HI, COLLECT and WRITE.
REQ-020 HDR_LO SHALL go to HDR_HI on a transfer, capturing N[7:0].
REQ-021 HDR_HI SHALL capture N[15:8] on a transfer, then go to ERR if N==0 or N>WORDS, else to COLLECT.
REQ-022 In COLLECT, the k-th accepted byte (k=0..3) SHALL fill word bits [8k+7:8k] (little-endian).
REQ-023 COLLECT SHALL go to WRITE on the edge that accepts byte k=3.
REQ-024 WRITE SHALL last exactly one cycle with memWrite=1, memAddress=BASE+4*wordIdx (32-bit wrap) and memData=the assembled word.
REQ-025 On leaving WRITE, wordIdx SHALL increment and the byte index SHALL clear.
REQ-026 WRITE SHALL go to DONE when the incremented wordIdx equals N, else to COLLECT.
REQ-027 memWrite SHALL be 0 in every state except WRITE.
REQ-028 memAddress and memData SHALL hold their last values outside WRITE.
REQ-029 busy SHALL be 1 in HDR_LO, HDR_HI, COLLECT and WRITE.
REQ-030 done SHALL be 1 only in DONE and error 1 only in ERR; both are sticky until the next honoured start.
REQ-031 cpuResetN SHALL be 1 only in DONE, releasing the datapath the cycle after the last write.
REQ-032 Bytes offered in IDLE, DONE, ERR or WRITE SHALL not be consumed; the source holds them.
REQ-033 There SHALL be no timeout: a stalled stream leaves the FSM waiting indefinitely.

Reset
REQ-034 reset=0 SHALL force, asynchronously, state=IDLE, N=0, wordIdx=0, byte index=0, assembled word=0.
REQ-035 reset=0 SHALL force, asynchronously, byteReady=0, memWrite=0, memAddress=BASE, memData=0, cpuResetN=0, busy=0, done=0, error=0.
REQ-036 A reset mid-session SHALL abort it with no further memWrite; words already written are not rolled back.

Verification
REQ-037 Reset, start, stream 02 00 13 05 00 00 93 05 10 00 with byteValid held 1 -> writes (0x0,0x00000513) then (0x4,0x00100593), done=1, cpuResetN=1, busy=0.
REQ-038 Same stream with byteValid toggled every other cycle -> identical writes; byteReady=0 in each WRITE cycle.
REQ-039 Header 00 00 -> ERR, error=1, no memWrite, cpuResetN=0; next start plus a valid stream -> done=1.
REQ-040 Header 41 00 (N=65, WORDS=64) -> error=1, byteReady=0 afterwards, no memWrite.
REQ-041 reset pulsed low after 2 payload bytes -> all outputs at reset values immediately; a new session then writes word 0 at 0x0.
REQ-042 start pulsed in COLLECT -> ignored; session completes with the same writes as REQ-037.
